// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock parametrised FIFO with a registered fill level,
//            combinational status flags, programmable almost-full and
//            almost-empty thresholds, and sticky overflow/underflow flags.
//            It can read in standard (registered) or first-word-fall-through
//            mode.
// Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter bit FWFT       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    input  logic                  clr_err,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic                  half,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                c_DEPTH_INT = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] c_HALF    = c_DEPTH >> 1;
    localparam logic [ADDR_WIDTH:0] c_ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] c_ZERO    = {(ADDR_WIDTH+1){1'b0}};

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH_INT];
    logic [ADDR_WIDTH:0]   r_wptr;
    logic [ADDR_WIDTH:0]   r_rptr;
    logic [ADDR_WIDTH:0]   r_level;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    // Accept only what the current occupancy allows; a full FIFO still
    // accepts a read, an empty one still accepts a write.
    assign w_wr_acc = wr_en && !full;
    assign w_rd_acc = rd_en && !empty;

    // Status flags come straight from the registered level.
    assign level        = r_level;
    assign full         = (r_level == c_DEPTH);
    assign empty        = (r_level == c_ZERO);
    assign half         = (r_level >= c_HALF);
    assign almost_full  = (r_level >= af_thresh);
    assign almost_empty = (r_level <= ae_thresh);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // Storage write; memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo 2*DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= c_ZERO;
            r_rptr  <= c_ZERO;
            r_level <= c_ZERO;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + c_ONE;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + c_ONE;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_level <= r_level + c_ONE;
                2'b01:   r_level <= r_level - c_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky error flags; a set event wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is presented combinationally; invalid while empty.
            assign data_out = r_mem[r_rptr[ADDR_WIDTH-1:0]];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_dout;

            // Registered read port; holds its value between accepted reads.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dout <= {DATA_WIDTH{1'b0}};
                end else if (w_rd_acc) begin
                    r_dout <= r_mem[r_rptr[ADDR_WIDTH-1:0]];
                end
            end

            assign data_out = r_dout;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo
// Purpose  : Self-checking bench for sync_fifo. A standard-mode and a
//            FWFT-mode instance share all stimulus and are compared against
//            a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [DW-1:0] data_in;
    logic          rd_en;
    logic          clr_err;
    logic [AW:0]   af_thresh;
    logic [AW:0]   ae_thresh;

    logic [DW-1:0] s_dout, f_dout;
    logic [AW:0]   s_level, f_level;
    logic          s_full, s_empty, s_half, s_af, s_ae, s_ovf, s_unf;
    logic          f_full, f_empty, f_half, f_af, f_ae, f_ovf, f_unf;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_ovf;
    logic          m_unf;

    sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b0)) u_std (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(s_dout), .af_thresh(af_thresh),
        .ae_thresh(ae_thresh), .clr_err(clr_err), .level(s_level),
        .full(s_full), .empty(s_empty), .half(s_half),
        .almost_full(s_af), .almost_empty(s_ae),
        .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(f_dout), .af_thresh(af_thresh),
        .ae_thresh(ae_thresh), .clr_err(clr_err), .level(f_level),
        .full(f_full), .empty(f_empty), .half(f_half),
        .almost_full(f_af), .almost_empty(f_ae),
        .overflow(f_ovf), .underflow(f_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every observable output against the model.
    task automatic check_all();
        int n;
        n = q.size();
        chk("level",        s_level, n);
        chk("full",         s_full,  (n == DEPTH));
        chk("empty",        s_empty, (n == 0));
        chk("half",         s_half,  (n >= DEPTH / 2));
        chk("almost_full",  s_af,    (n >= int'(af_thresh)));
        chk("almost_empty", s_ae,    (n <= int'(ae_thresh)));
        chk("overflow",     s_ovf,   m_ovf);
        chk("underflow",    s_unf,   m_unf);
        chk("data_out",     s_dout,  m_dout);
        chk("fwft_level",   f_level, n);
        chk("fwft_empty",   f_empty, (n == 0));
        chk("fwft_full",    f_full,  (n == DEPTH));
        chk("fwft_ovf",     f_ovf,   m_ovf);
        chk("fwft_unf",     f_unf,   m_unf);
        if (n > 0) begin
            chk("fwft_data_out", f_dout, q[0]);
        end
    endtask

    // One clock cycle of stimulus; the model applies the same rules at the edge.
    task automatic step(input logic wr, input logic [DW-1:0] din, input logic rd, input logic clr);
        int  n;
        bit  wa, ra;
        wr_en   = wr;
        data_in = din;
        rd_en   = rd;
        clr_err = clr;
        @(posedge clk);
        n  = q.size();
        wa = wr && (n != DEPTH);
        ra = rd && (n != 0);
        if (wr && n == DEPTH) m_ovf = 1'b1;
        else if (clr)         m_ovf = 1'b0;
        if (rd && n == 0)     m_unf = 1'b1;
        else if (clr)         m_unf = 1'b0;
        if (ra) m_dout = q.pop_front();
        if (wa) q.push_back(din);
        #1;
        check_all();
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        clr_err   = 1'b0;
        data_in   = '0;
        af_thresh = '0;
        ae_thresh = 7'd4;
        model_reset();

        // Reset state, including almost_full forced high by af_thresh = 0
        #3;
        check_all();
        chk("rst_af_zero_thresh", s_af, 1'b1);
        af_thresh = 7'd48;
        #1;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fill 0x00..0x3F; switch af_thresh to 40 at level 45
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, DW'(i), 1'b0, 1'b0);
            if (i == 31) chk("half_after_32", s_half, 1'b1);
            if (i == 44) begin
                chk("af_below_48", s_af, 1'b0);
                af_thresh = 7'd40;
                #1;
                chk("af_thresh_40_at_45", s_af, 1'b1);
                af_thresh = 7'd48;
                #1;
            end
        end
        chk("full_after_64", s_full, 1'b1);

        // Overflow behaviour at full
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        step(1'b1, 8'hFE, 1'b0, 1'b1);
        chk("ovf_set_beats_clear", s_ovf, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        chk("full_rw_level_63", s_level, 7'd63);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Drain and underflow, data_out must hold the last word
        for (int i = 0; i < DEPTH - 1; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_hold_3f", s_dout, 8'h3F);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Simultaneous at empty: write lands, underflow sets
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        chk("empty_rw_level_1", s_level, 7'd1);
        chk("fwft_a5", f_dout, 8'hA5);
        step(1'b0, 8'h00, 1'b1, 1'b1);

        // Sustained read+write at level 10
        for (int i = 0; i < 10; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, DW'($urandom), 1'b1, 1'b0);
        chk("rw_level_10", s_level, 7'd10);

        // Randomised traffic with write-heavy and read-heavy phases
        for (int i = 0; i < 3000; i++) begin
            int wp;
            wp = ((i / 200) % 2 == 0) ? 75 : 25;
            if ($urandom_range(0, 99) == 0) begin
                af_thresh = 7'($urandom_range(0, 70));
                ae_thresh = 7'($urandom_range(0, 70));
            end
            step(1'($urandom_range(0, 99) < wp), DW'($urandom),
                 1'($urandom_range(0, 99) < 100 - wp),
                 1'($urandom_range(0, 19) == 0));
        end
        af_thresh = 7'd48;
        ae_thresh = 7'd4;

        // Clean reset, provoke underflow, then reset mid-burst at level 30
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        chk("pre_reset_level_30", s_level, 7'd30);
        wr_en = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("async_rst_level", s_level, 7'd0);
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
